tiny_rv_fetch: RTL
==================

# tiny_rv_fetch

Instruction fetch stage of the tiny_rv core, directly upstream of decode. Issues word-aligned requests on the instruction memory port and tracks up to two in-flight requests. Buffers returned words with their PCs in a 2-entry FIFO and presents the head on `fetch_pc`/`fetch_inst`. On a redirect it discards in-flight and buffered work and restarts at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_pipe_stall`  in  1  decode not accepting this cycle; same signal decode receives.
- `i_redirect`  in  1  discard all fetch state and restart at `i_redirect_pc`. The controller asserts decode's `i_pipe_flush` in the same cycle.
- `i_redirect_pc`  in  32  new PC; bits [1:0] ignored and treated as 0.
- `o_imem_req_valid`  out  1  request valid.
- `o_imem_req_addr`  out  32  request byte address, always word aligned.
- `i_imem_req_ready`  in  1  memory accepts request; handshake fires on valid&&ready.
- `i_imem_rsp_valid`  in  1  response word valid.
  - Responses arrive in order, at least 1 cycle after acceptance.
  - There is no response backpressure.
- `i_imem_rsp_data`  in  32  instruction word.
- `fetch_pc`  out  32  PC of head instruction, 0 when empty.
- `fetch_inst`  out  32  head instruction, 0 (bubble) when empty.
- `fetch_valid`  out  1  FIFO non-empty.

## Operation
- State registers:
  - `req_pc`: next address to request.
  - `rsp_pc`: PC of the next accepted response.
  - `out_cnt` 0..2: in-flight requests, including ones to be dropped.
  - `drop_cnt` 0..2: in-flight responses to discard.
  - 2-entry FIFO of {pc, inst}.
  - `occ` 0..2: FIFO occupancy.
- `pop = fetch_valid && !i_pipe_stall`. Decode latches the head on the same edge.
- Credit check: `out_cnt + occ - pop < 2`.
- `o_imem_req_valid = credit && !i_redirect && !i_reset`. `o_imem_req_addr = req_pc`.
- The memory port tolerates valid being withdrawn without ready.
- On request fire: `req_pc += 4` (mod 2^32, wraps FFFF_FFFC→0) and `out_cnt++`.
- On response while `drop_cnt > 0`: the word is discarded, `drop_cnt--`, `out_cnt--`.
- On response while `drop_cnt == 0`: {rsp_pc, data} is pushed, `rsp_pc += 4`, `out_cnt--`.
- A fire and a response in the same cycle leave `out_cnt` unchanged.
- Push and pop may occur in the same cycle. The credit rule guarantees a push never finds the FIFO full.
- Outputs come straight from the FIFO head register, so there is no combinational path from `i_imem_rsp_*`.
- On redirect (overrides everything else in that cycle):
  - FIFO cleared; no pop counted, since decode is flushed.
  - `req_pc = rsp_pc = i_redirect_pc & ~3`.
  - `drop_cnt = out_cnt - i_imem_rsp_valid`; a response arriving that cycle is discarded.
  - `out_cnt` is likewise reduced by an arriving response.
  - No request is issued that cycle.
- Back-to-back redirects: the last one wins; `drop_cnt` is recomputed from the current `out_cnt`.
- Reset values:
  - `req_pc = rsp_pc = RESET_PC`.
  - `out_cnt = drop_cnt = occ = 0`.
  - FIFO entries 0.
  - `fetch_pc = fetch_inst = 0`, `fetch_valid = 0`, `o_imem_req_valid = 0`.
- Reset mid-operation abandons in-flight requests. The memory is reset concurrently by the same `i_reset`.

## Timing
- Request accepted in cycle N; earliest response in N+1.
- Pushed word visible on `fetch_*` in N+2; decode registers it at the end of N+2.
- With single-cycle memory, `i_imem_req_ready` = 1 and no stall, steady throughput is 1 instruction per cycle, starting with `o_imem_req_valid` = 1 in the first cycle after reset deasserts.
- `o_imem_req_valid` depends combinationally on `i_pipe_stall` and `i_redirect`. `fetch_*` are registered only.
- After a redirect in cycle R, the request to the new PC is issued in R+1. The earliest new instruction appears on `fetch_*` in R+3.

## Test plan
- **Reset/stream:** `RESET_PC`=0x100, 1-cycle memory returning addr^0xA5A5_0000, no stall.
  - Required: requests 0x100, 0x104, ... every cycle.
  - Required: `fetch_pc`/`fetch_inst` = 0x100/0xA5A5_0100 two cycles after the first fire, then one per cycle.
- **Stall:** hold `i_pipe_stall` for 5 cycles mid-stream.
  - Required: head held constant, `occ` reaches 2, `o_imem_req_valid` = 0 while `out_cnt + occ` = 2.
  - Required: after release, no PC skipped or duplicated.
- **Redirect with in-flight work:** 2 requests outstanding on a 3-cycle-latency memory, `i_redirect`=1 with pc 0x2002.
  - Required: both old responses dropped; the next request is 0x2000 one cycle later; the first delivered instruction has `fetch_pc` = 0x2000.
- **Redirect coincident with a response:**
  - Required: that word is not pushed, and the remaining in-flight response is dropped.
- **Request backpressure and wrap:** `i_imem_req_ready` toggles pseudo-randomly from `req_pc` = 0xFFFF_FFF8.
  - Required: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, each requested exactly once, in order.
- **Async reset mid-stream:** assert `i_reset` between clock edges.
  - Required: `fetch_*` = 0 and `o_imem_req_valid` = 0 immediately.
  - Required: after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/tiny_rv_fetch.sv
// tiny_rv_fetch: instruction fetch stage of the tiny_rv core.
// Issues word-aligned requests on the instruction memory port, keeps at most
// two requests in flight, and buffers returned words with their PCs in a
// 2-entry FIFO. The FIFO head drives decode. A redirect discards buffered and
// in-flight work and restarts at the new PC.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_pipe_stall              decode not accepting the head this cycle
//   i_redirect, i_redirect_pc restart fetch at i_redirect_pc (bits [1:0] ignored)
//   o_imem_req_valid/addr     request channel, i_imem_req_ready accepts
//   i_imem_rsp_valid/data     in-order response channel, no backpressure
//   fetch_pc/inst/valid       registered FIFO head (zeros when empty)
module tiny_rv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        fetch_valid
);

  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;
  logic [1:0]  occ_q, occ_d;
  // Entry 0 is always the head; entries are zeroed whenever vacated so the
  // fetch outputs read as zero when the FIFO is empty.
  logic [31:0] e0_pc_q, e0_pc_d, e0_inst_q, e0_inst_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_inst_q, e1_inst_d;

  logic        pop_s;
  logic        credit_s;
  logic        fire_s;
  logic        rsp_s;
  logic        push_s;
  logic [2:0]  credit_sum_s;
  logic [1:0]  occ_after_pop_s;

  // Handshake decode, credit check and request channel.
  always_comb begin
    pop_s            = (occ_q != 2'd0) && !i_pipe_stall;
    credit_sum_s     = {1'b0, out_cnt_q} + {1'b0, occ_q} - {2'b00, pop_s};
    credit_s         = (credit_sum_s < 3'd2);
    o_imem_req_valid = credit_s && !i_redirect && !i_reset;
    o_imem_req_addr  = req_pc_q;
    fire_s           = o_imem_req_valid && i_imem_req_ready;
    // A response with nothing outstanding is protocol-illegal; ignore it
    // rather than let the counters wrap.
    rsp_s            = i_imem_rsp_valid && (out_cnt_q != 2'd0);
    push_s           = rsp_s && (drop_cnt_q == 2'd0);
  end

  // Next-state logic for counters, PCs and FIFO.
  always_comb begin
    req_pc_d        = req_pc_q;
    rsp_pc_d        = rsp_pc_q;
    out_cnt_d       = out_cnt_q;
    drop_cnt_d      = drop_cnt_q;
    occ_d           = occ_q;
    e0_pc_d         = e0_pc_q;
    e0_inst_d       = e0_inst_q;
    e1_pc_d         = e1_pc_q;
    e1_inst_d       = e1_inst_q;
    occ_after_pop_s = occ_q;
    if (i_redirect) begin
      // Everything still in flight (less a word arriving now) becomes junk.
      req_pc_d   = {i_redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {i_redirect_pc[31:2], 2'b00};
      out_cnt_d  = out_cnt_q - {1'b0, rsp_s};
      drop_cnt_d = out_cnt_q - {1'b0, rsp_s};
      occ_d      = 2'd0;
      e0_pc_d    = 32'h0000_0000;
      e0_inst_d  = 32'h0000_0000;
      e1_pc_d    = 32'h0000_0000;
      e1_inst_d  = 32'h0000_0000;
    end else begin
      if (fire_s) begin
        req_pc_d = req_pc_q + 32'd4;
      end else begin
        req_pc_d = req_pc_q;
      end
      out_cnt_d = out_cnt_q + {1'b0, fire_s} - {1'b0, rsp_s};
      if (rsp_s && !push_s) begin
        drop_cnt_d = drop_cnt_q - 2'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (pop_s) begin
        e0_pc_d   = e1_pc_q;
        e0_inst_d = e1_inst_q;
        e1_pc_d   = 32'h0000_0000;
        e1_inst_d = 32'h0000_0000;
      end else begin
        e0_pc_d   = e0_pc_q;
        e0_inst_d = e0_inst_q;
      end
      occ_after_pop_s = occ_q - {1'b0, pop_s};
      if (push_s) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        case (occ_after_pop_s)
          2'd0: begin
            e0_pc_d   = rsp_pc_q;
            e0_inst_d = i_imem_rsp_data;
          end
          2'd1: begin
            e1_pc_d   = rsp_pc_q;
            e1_inst_d = i_imem_rsp_data;
          end
          default: begin
            // Unreachable: the credit check keeps a slot free for every response.
            e1_pc_d   = e1_pc_q;
            e1_inst_d = e1_inst_q;
          end
        endcase
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
      occ_d = occ_after_pop_s + {1'b0, push_s};
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      req_pc_q   <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= 2'd0;
      drop_cnt_q <= 2'd0;
      occ_q      <= 2'd0;
      e0_pc_q    <= 32'h0000_0000;
      e0_inst_q  <= 32'h0000_0000;
      e1_pc_q    <= 32'h0000_0000;
      e1_inst_q  <= 32'h0000_0000;
    end else begin
      req_pc_q   <= req_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      occ_q      <= occ_d;
      e0_pc_q    <= e0_pc_d;
      e0_inst_q  <= e0_inst_d;
      e1_pc_q    <= e1_pc_d;
      e1_inst_q  <= e1_inst_d;
    end
  end

  // Decode sees the FIFO head registers directly.
  always_comb begin
    fetch_pc    = e0_pc_q;
    fetch_inst  = e0_inst_q;
    fetch_valid = (occ_q != 2'd0);
  end

endmodule
